// File: rtl/display_arbiter.sv
// Round-robin arbiter that time-shares the 4-digit 7-segment display between requesters A and B.
// Optional DISPLAY_ARB_REFRESH_EN lets the current owner update its value during HOLD.
module display_arbiter #(
  parameter int DWELL   = 25_000_000,
  parameter int DWELL_W = 25
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_a,
  input  logic [15:0] data_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  output logic        ack_b,
  output logic [3:0]  cifra0,
  output logic [3:0]  cifra1,
  output logic [3:0]  cifra2,
  output logic [3:0]  cifra3,
  output logic        owner,
  output logic        valid,
  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 last_owner_q;
  logic                 req_a_ok, req_b_ok;
  logic                 grant_a, grant_b;
  logic [15:0]          sel_data;

  // Handshake: req is a level held until the requester sees its one-cycle ack;
  // a req still high while its own ack is high is the tail of the old request.
  assign req_a_ok = req_a & ~ack_a;
  assign req_b_ok = req_b & ~ack_b;
  assign sel_data = grant_b ? data_b : data_a;

  // busy is the state register itself, so it also serves as the FSM debug view.
  assign busy = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the side that did not own the display last time wins.
        grant_b = req_b_ok & (~req_a_ok | ~last_owner_q);
        grant_a = req_a_ok & ~grant_b;
        if (grant_a || grant_b) begin
          state_d = HOLD;
          cnt_d   = DWELL_W'(DWELL - 1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
`ifdef DISPLAY_ARB_REFRESH_EN
        // Owner refresh: new data and ack, but the dwell end is not moved.
        grant_a = ~owner & req_a_ok;
        grant_b =  owner & req_b_ok;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
      owner        <= 1'b0;
      last_owner_q <= 1'b1;
      valid        <= 1'b0;
      cifra0       <= 4'h0;
      cifra1       <= 4'h0;
      cifra2       <= 4'h0;
      cifra3       <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_a   <= grant_a;
      ack_b   <= grant_b;
      if (grant_a || grant_b) begin
        cifra0       <= sel_data[3:0];
        cifra1       <= sel_data[7:4];
        cifra2       <= sel_data[11:8];
        cifra3       <= sel_data[15:12];
        owner        <= grant_b;
        last_owner_q <= grant_b;
        valid        <= 1'b1;
      end
    end
  end

endmodule
